// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS sample path and its serial DAC back end.
package dds_pkg;

  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned DEFAULT_CLK_DIV = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } ser_state_t;

endpackage

// File: rtl/dds_dac_serializer_bit_timer.sv
// Bit-period phase counter for the serial DAC link: CLK_DIV cycles with sclk low,
// then CLK_DIV cycles with sclk high, restartable from phase 0.
module serial_bit_timer #(
  parameter int unsigned CLK_DIV = dds_pkg::DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  output logic sclk_level,
  output logic bit_start,
  output logic bit_end
);

  localparam int unsigned PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] LAST    = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] HALF_M1 = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase;

  // sclk_level is registered from the upcoming phase so it lines up with phase itself.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      phase      <= '0;
      sclk_level <= 1'b0;
    end else if (en) begin
      if (phase == LAST) begin
        phase      <= '0;
        sclk_level <= 1'b0;
      end else begin
        phase      <= phase + 1'b1;
        sclk_level <= (phase >= HALF_M1);
      end
    end
  end

  assign bit_start = en && (phase == '0);
  assign bit_end   = en && (phase == LAST);

endmodule

// File: rtl/dds_dac_serializer.sv
// Captures DDS samples into a one-entry holding register and shifts them MSB-first
// to a serial DAC with a frame sync on the MSB bit period.
module dds_dac_serializer
  import dds_pkg::*;
#(
  parameter int unsigned W       = SAMPLE_W,
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sample,
  input  logic         new_sample_ready,
  input  logic         clr_overrun,
  output logic         dac_sclk,
  output logic         dac_sdata,
  output logic         dac_fs,
  output logic         busy,
  output logic         overrun
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  ser_state_t    state;
  logic [W-1:0]  hold;
  logic          hold_valid;
  logic [W-1:0]  shreg;
  logic [CW-1:0] bit_cnt;

  logic take;
  logic bit_start;
  logic bit_end;
  logic sclk_level;

  assign take = (state == IDLE) && hold_valid;

  serial_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (take),
    .en         (state == SHIFT),
    .sclk_level (sclk_level),
    .bit_start  (bit_start),
    .bit_end    (bit_end)
  );

  assign dac_sclk = sclk_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      dac_sdata  <= 1'b0;
      dac_fs     <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (new_sample_ready && (!hold_valid || take)) begin
        hold       <= sample;
        hold_valid <= 1'b1;
      end else if (take) begin
        hold_valid <= 1'b0;
      end

      if (new_sample_ready && hold_valid && !take) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      // Next-cycle view of (state != IDLE) | hold_valid.
      busy <= take || (state == SHIFT) || new_sample_ready || (hold_valid && !take);

      case (state)
        IDLE: begin
          if (hold_valid) begin
            shreg     <= hold;
            bit_cnt   <= LAST_BIT;
            dac_sdata <= hold[W-1];
            dac_fs    <= 1'b1;
            state     <= SHIFT;
          end else begin
            dac_sdata <= 1'b0;
            dac_fs    <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_end) begin
            dac_fs <= 1'b0;
            if (bit_cnt == '0) begin
              dac_sdata <= 1'b0;
              state     <= GAP;
            end else begin
              shreg     <= shreg << 1;
              bit_cnt   <= bit_cnt - 1'b1;
              dac_sdata <= shreg[W-2];
            end
          end
        end
        GAP: begin
          dac_sdata <= 1'b0;
          dac_fs    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          dac_sdata <= 1'b0;
          dac_fs    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  a_bit_starts_low: assert property (@(posedge clk) disable iff (reset)
    bit_start |-> !dac_sclk);

endmodule

// File: tb/tb_dds_dac_serializer.sv
// Directed bench for dds_dac_serializer: a negedge monitor deserializes DAC frames
// and the checks compare them against hand-computed words and timings.
module tb_dds_dac_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample;
  logic        new_sample_ready;
  logic        clr_overrun;
  logic        dac_sclk, dac_sdata, dac_fs, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dds_dac_serializer #(
    .W       (16),
    .CLK_DIV (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sample           (sample),
    .new_sample_ready (new_sample_ready),
    .clr_overrun      (clr_overrun),
    .dac_sclk         (dac_sclk),
    .dac_sdata        (dac_sdata),
    .dac_fs           (dac_fs),
    .busy             (busy),
    .overrun          (overrun)
  );

  // Monitor: shift in sdata on each rising sclk, frame starts when fs is high.
  logic [15:0] frames[$];
  int          starts[$];
  int          fs_lens[$];
  logic [15:0] cur = '0;
  int          nb = 0;
  int          fs_run = 0;
  int          cyc = 0;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_sclk <= dac_sclk;
    if (reset) begin
      nb     <= 0;
      fs_run <= 0;
    end else begin
      if (dac_sclk && !prev_sclk) begin
        if (dac_fs) begin
          cur <= {15'b0, dac_sdata};
          nb  <= 1;
          starts.push_back(cyc);
        end else begin
          cur <= {cur[14:0], dac_sdata};
          nb  <= nb + 1;
          if (nb == 15) frames.push_back({cur[14:0], dac_sdata});
        end
      end
      if (dac_fs) begin
        fs_run <= fs_run + 1;
      end else if (fs_run != 0) begin
        fs_lens.push_back(fs_run);
        fs_run <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] val, input logic clr);
    sample           = val;
    new_sample_ready = 1'b1;
    clr_overrun      = clr;
    tick();
    new_sample_ready = 1'b0;
    clr_overrun      = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall);
    fall = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (!busy) begin
        fall = k;
        break;
      end
    end
  endtask

  task automatic clear_mon();
    frames.delete();
    starts.delete();
    fs_lens.delete();
  endtask

  function automatic logic [31:0] frame_at(input int i);
    return (i < frames.size()) ? {16'h0, frames[i]} : 32'hDEAD_BEEF;
  endfunction

  typedef struct {
    logic [15:0] smp;
    logic [15:0] bits;
    int          fs_len;
    int          busy_fall;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fall;
    int fs_first;

    vecs[0] = '{16'hA5C3, 16'b1010010111000011, 8, 130};
    vecs[1] = '{16'h7FFF, 16'b0111111111111111, 8, 130};
    vecs[2] = '{16'h8000, 16'b1000000000000000, 8, 130};
    vecs[3] = '{16'h0001, 16'b0000000000000001, 8, 130};
    vecs[4] = '{16'hFFFE, 16'b1111111111111110, 8, 130};
    vecs[5] = '{16'h1234, 16'b0001001000110100, 8, 130};

    reset = 1'b1; sample = '0; new_sample_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {27'b0, dac_sclk, dac_sdata, dac_fs, busy, overrun}, 32'h0);
    reset = 1'b0;
    tick();

    // Single frames
    foreach (vecs[i]) begin
      clear_mon();
      strobe(vecs[i].smp, 1'b0);
      fs_first = -1;
      fall = -1;
      for (int k = 1; k <= 300; k++) begin
        tick();
        if (dac_fs && fs_first < 0) fs_first = k;
        if (!busy) begin
          fall = k;
          break;
        end
      end
      check($sformatf("v%0d_busy_fall", i), fall, vecs[i].busy_fall);
      check($sformatf("v%0d_fs_first", i), fs_first, 1);
      check($sformatf("v%0d_frames", i), frames.size(), 1);
      check($sformatf("v%0d_bits", i), frame_at(0), {16'h0, vecs[i].bits});
      check($sformatf("v%0d_fs_len", i), (fs_lens.size() > 0) ? fs_lens[0] : -1, vecs[i].fs_len);
      check($sformatf("v%0d_overrun", i), overrun, 0);
      tick();
    end

    // Two strobes 20 apart: second is held and sent back-to-back
    clear_mon();
    strobe(16'h7FFF, 1'b0);
    repeat (19) tick();
    strobe(16'h8000, 1'b0);
    wait_idle(400, fall);
    check("b2b_timeout", (fall > 0), 1);
    check("b2b_frames", frames.size(), 2);
    check("b2b_f0", frame_at(0), 32'h7FFF);
    check("b2b_f1", frame_at(1), 32'h8000);
    check("b2b_spacing", (starts.size() == 2) ? starts[1] - starts[0] : -1, 130);
    check("b2b_overrun", overrun, 0);

    // Three strobes: third dropped
    clear_mon();
    strobe(16'h1111, 1'b0);
    repeat (19) tick();
    strobe(16'h2222, 1'b0);
    repeat (19) tick();
    strobe(16'h3333, 1'b0);
    check("ovr_set", overrun, 1);
    wait_idle(400, fall);
    check("ovr_frames", frames.size(), 2);
    check("ovr_f0", frame_at(0), 32'h1111);
    check("ovr_f1", frame_at(1), 32'h2222);
    check("ovr_sticky", overrun, 1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Clear coincident with a new overrun: set wins
    strobe(16'h4444, 1'b0);
    repeat (19) tick();
    strobe(16'h5555, 1'b0);
    check("coinc_pre", overrun, 0);
    repeat (19) tick();
    strobe(16'h6666, 1'b1);
    check("coinc_set_wins", overrun, 1);
    wait_idle(400, fall);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;

    // Reset during bit 7 aborts the frame
    strobe(16'hFFFF, 1'b0);
    repeat (59) tick();
    check("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("mid_reset_outputs", {27'b0, dac_sclk, dac_sdata, dac_fs, busy, overrun}, 32'h0);
    reset = 1'b0;
    tick();
    clear_mon();
    strobe(16'h3C5A, 1'b0);
    wait_idle(300, fall);
    check("post_reset_fall", fall, 130);
    check("post_reset_frames", frames.size(), 1);
    check("post_reset_bits", frame_at(0), 32'h3C5A);

    // DDS-like source: phase += 4096 per pulse, sample = phase[21:6], pulse every 200
    clear_mon();
    for (int n = 1; n <= 4; n++) begin
      strobe(16'(n * 64), 1'b0);
      repeat (199) tick();
    end
    wait_idle(300, fall);
    check("dds_frames", frames.size(), 4);
    for (int n = 0; n < 4; n++) check($sformatf("dds_f%0d", n), frame_at(n), 32'((n + 1) * 64));
    check("dds_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dds_dac_serializer.md
Name: dds_dac_serializer

Overview:
Consumer end of the DDS sample interface.
- Captures each 16-bit two's-complement sample qualified by new_sample_ready.
- Buffers it in a one-entry holding register.
- Shifts it MSB-first to an external serial DAC as dac_sclk / dac_sdata / dac_fs.
- Sits directly after the DDS core. Its sample/new_sample_ready inputs connect to the DDS outputs of the same names.

Parameters:
W, 16, sample width in bits (matches the DDS output).
CLK_DIV, 4, clk cycles per dac_sclk half-period (>=1). One bit period is 2*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
sample  input  W  two's-complement sample; valid only while new_sample_ready=1.
new_sample_ready  input  1  one-cycle strobe: sample is valid this cycle.
clr_overrun  input  1  synchronous clear of the overrun flag.
dac_sclk  output  1  serial bit clock to the DAC.
dac_sdata  output  1  serial data, MSB first.
dac_fs  output  1  frame sync; high during the MSB bit period only.
busy  output  1  high while a frame is shifting or the holding register is full.
overrun  output  1  sticky: a sample was dropped.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values: dac_sclk=0, dac_sdata=0, dac_fs=0, busy=0, overrun=0, hold_valid=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame immediately. There is no partial-frame completion.
- Holding register (hold, hold_valid):
  - On new_sample_ready=1 with hold_valid=0, or with hold_valid=1 being emptied in the same cycle: hold<=sample, hold_valid<=1.
  - On new_sample_ready=1 while hold_valid=1 and hold is not emptied that cycle: the new sample is dropped, the old one is kept, overrun<=1.
- overrun:
  - Cleared by clr_overrun.
  - If a set event and clr_overrun occur in the same cycle, the set wins.
- State machine states: IDLE, SHIFT, GAP.
- IDLE:
  - Outputs dac_sclk=0, dac_fs=0, dac_sdata=0.
  - If hold_valid=1: shreg<=hold, hold_valid<=0, bit_cnt<=W-1, phase counter<=0, go to SHIFT.
- SHIFT:
  - Each bit period is CLK_DIV cycles with dac_sclk=0, then CLK_DIV cycles with dac_sclk=1.
  - dac_sdata=shreg[W-1] is driven from the start of the bit period. It is stable across the rising edge of dac_sclk.
  - dac_fs=1 only while bit_cnt=W-1.
  - At the end of each bit period, shreg shifts left by 1 and bit_cnt decrements.
  - At the end of the bit with bit_cnt=0: go to GAP.
- GAP:
  - Exactly one clk cycle with all DAC outputs at 0, then go to IDLE.
  - This guarantees a dac_sclk low time between frames.
- Latency:
  - new_sample_ready high at edge E (hold empty, IDLE): hold is loaded at E, SHIFT is entered at E+1.
  - dac_fs=1 and dac_sdata=MSB are visible after edge E+1.
- Frame length: W*2*CLK_DIV cycles in SHIFT, plus 1 in GAP, plus 1 in IDLE.
  - Back-to-back frames therefore need a sample spacing of at least W*2*CLK_DIV+2 clk cycles.
  - Closer spacing is absorbed once by hold; a third sample inside that window overruns.
- busy = (state!=IDLE) | hold_valid.
- sample is treated as an opaque bit vector. There is no sign conversion and the data is transmitted as received.

Decomposition:
- Shared package dds_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - the default sample width constant SAMPLE_W=16, shared with the DDS core;
  - the default CLK_DIV.
- One sub-module, serial_bit_timer:
  - Phase counter 0..2*CLK_DIV-1 with an enable input.
  - Produces sclk_level, bit_start and bit_end strobes.
  - Restarts at 0 when its start input is asserted.

Test Plan:
- Reset, then a single strobe with sample=16'hA5C3, CLK_DIV=4:
  - dac_fs high for exactly 8 cycles, starting one cycle after the strobe.
  - The bits sampled at the 16 dac_sclk rising edges are 1010010111000011.
  - busy falls 130 cycles after the strobe.
- Two strobes 20 cycles apart with 16'h7FFF then 16'h8000:
  - Second sample held; overrun stays 0.
  - Frames are sent back-to-back with a 2-cycle gap (GAP plus IDLE).
  - Second frame bits are 1000000000000000.
- Three strobes 20 cycles apart:
  - Third sample is dropped and overrun=1.
  - Only two frames are sent.
  - Pulsing clr_overrun clears the flag.
- clr_overrun coincident with a new overrun event -> overrun remains 1.
- Assert reset during bit 7 of a frame:
  - Next cycle, all outputs are 0 and busy=0.
  - A strobe after reset yields a complete, correct frame.
- DDS in the loop with k=22'd4096 and sampling_pulse every 200 cycles:
  - The deserialized frame values match the DDS sample values in order.
  - overrun stays 0.
